// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one
// bit per cycle, fixed latency of WIDTH+2 clocks from accepted start to done.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] leftOperand,
  input  logic [WIDTH-1:0] rightOperand,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             divideByZero
);

  localparam int CountW = $clog2(WIDTH);
  localparam logic [CountW-1:0] countLast = CountW'(WIDTH - 1);

  localparam logic [2:0] opMul  = 3'd0;
  localparam logic [2:0] opMulu = 3'd1;
  localparam logic [2:0] opDiv  = 3'd2;
  localparam logic [2:0] opDivu = 3'd3;
  localparam logic [2:0] opRem  = 3'd4;
  localparam logic [2:0] opRemu = 3'd5;

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t state, stateNext;

  logic [2:0]        opReg;
  logic [WIDTH:0]    accHi;
  logic [WIDTH-1:0]  accLo;
  logic [WIDTH-1:0]  addend;
  logic [CountW-1:0] count;
  logic              negResult;
  logic              zeroDivisor;

  logic isMul, isDiv, isRem, isSigned, isReserved;
  logic [WIDTH-1:0] mulAddend;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic [WIDTH+1:0] divDiff;
  logic             divFits;
  logic [WIDTH-1:0] magResult;
  logic [WIDTH-1:0] fixedResult;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic signedOp);
    logic signed [WIDTH-1:0] negV;
    negV = -v;
    return (signedOp && (v < 0)) ? $unsigned(negV) : $unsigned(v);
  endfunction

  // Two's-complement negate modulo 2^WIDTH, so MIN stays MIN.
  function automatic logic [WIDTH-1:0] applySign(input logic [WIDTH-1:0] mag,
                                                 input logic neg);
    logic signed [WIDTH-1:0] s;
    s = -$signed(mag);
    return neg ? $unsigned(s) : mag;
  endfunction

  assign isMul      = (opReg == opMul) || (opReg == opMulu);
  assign isRem      = (opReg == opRem) || (opReg == opRemu);
  assign isDiv      = (opReg == opDiv) || (opReg == opDivu) || isRem;
  assign isSigned   = (opReg == opMul) || (opReg == opDiv) || (opReg == opRem);
  assign isReserved = !isMul && !isDiv;

  assign mulAddend = accLo[0] ? addend : '0;
  assign mulSum    = accHi + {1'b0, mulAddend};
  assign divShift  = {accHi[WIDTH-1:0], accLo[WIDTH-1]};
  assign divDiff   = {1'b0, divShift} - {2'b00, addend};
  assign divFits   = !divDiff[WIDTH+1];

  assign magResult   = isRem ? accHi[WIDTH-1:0] : accLo;
  assign fixedResult = (isReserved || (isDiv && zeroDivisor)) ? '0
                                                              : applySign(magResult, negResult);

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (start) stateNext = PREP;
      PREP: stateNext = RUN;
      RUN:  if (count == countLast) stateNext = FIX;
      FIX:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: operand capture, sign preparation, one iteration per RUN cycle.
  always_ff @(posedge clk) begin
    unique case (state)
      IDLE: begin
        if (start) begin
          opReg  <= operation;
          accLo  <= leftOperand;
          addend <= rightOperand;
        end
      end
      PREP: begin
        accHi <= '0;
        count <= '0;
        // Multiply iterates over the multiplier in accLo and adds the multiplicand.
        if (isMul) begin
          accLo  <= magnitude(addend, isSigned);
          addend <= magnitude(accLo, isSigned);
        end else begin
          accLo  <= magnitude(accLo, isSigned);
          addend <= magnitude(addend, isSigned);
        end
        negResult   <= isSigned && (isRem ? accLo[WIDTH-1]
                                          : (accLo[WIDTH-1] ^ addend[WIDTH-1]));
        zeroDivisor <= (addend == '0);
      end
      RUN: begin
        count <= count + CountW'(1);
        if (isMul) begin
          accHi <= {1'b0, mulSum[WIDTH:1]};
          accLo <= {mulSum[0], accLo[WIDTH-1:1]};
        end else if (isDiv) begin
          accHi <= divFits ? divDiff[WIDTH:0] : divShift;
          accLo <= {accLo[WIDTH-2:0], divFits};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done         <= 1'b0;
      result       <= '0;
      divideByZero <= 1'b0;
    end else begin
      done <= (state == FIX);
      if (state == FIX) begin
        result       <= fixedResult;
        divideByZero <= isDiv && zeroDivisor;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit at WIDTH=32 and WIDTH=8 against an
// arithmetic reference model.
module tb_mul_div_unit;

  localparam int LAT32 = 34;
  localparam int LAT8  = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    int          doneEdge;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t e32, e8;

  function automatic exp_t refModel(input int w, input logic [2:0] op,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input int doneEdge);
    exp_t    e;
    longint  mask, ua, ub, sa, sb, r;
    logic    z;
    mask = (longint'(1) << w) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = ua[w-1] ? ua - (longint'(1) << w) : ua;
    sb = ub[w-1] ? ub - (longint'(1) << w) : ub;
    r = 0;
    z = 1'b0;
    case (op)
      3'd0: r = sa * sb;
      3'd1: r = ua * ub;
      3'd2, 3'd3, 3'd4, 3'd5: begin
        if (ub == 0) z = 1'b1;
        else case (op)
          3'd2:    r = sa / sb;
          3'd3:    r = ua / ub;
          3'd4:    r = sa % sb;
          default: r = ua % ub;
        endcase
      end
      default: r = 0;
    endcase
    e.res = 32'(r & mask);
    e.dbz = z;
    e.doneEdge = doneEdge;
    return e;
  endfunction

  logic        rst32, start32, busy32, done32, dbz32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, res32;
  logic        rst8, start8, busy8, done8, dbz8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, res8;

  mul_div_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(rst32), .start(start32), .operation(op32),
    .leftOperand(a32), .rightOperand(b32), .busy(busy32), .done(done32),
    .result(res32), .divideByZero(dbz32));

  mul_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst8), .start(start8), .operation(op8),
    .leftOperand(a8), .rightOperand(b8), .busy(busy8), .done(done8),
    .result(res8), .divideByZero(dbz8));

  logic        prevDone32 = 1'b0, prevDone8 = 1'b0;
  logic [31:0] lastRes32 = '0;
  logic [7:0]  lastRes8 = '0;
  logic        busyExp32, busyExp8;
  int          doneCount32 = 0;

  always @(negedge clk) begin
    if (rst32) begin
      lastRes32  = '0;
      prevDone32 = 1'b0;
    end else begin
      if (done32) begin
        doneCount32++;
        if (q32.size() == 0) check("unexpected_done32", 1, 0);
        else begin
          e32 = q32.pop_front();
          check("result32", res32, e32.res);
          check("dbz32", dbz32, e32.dbz);
          check("latency32", cyc, e32.doneEdge);
        end
        check("donePulse32", prevDone32, 0);
        lastRes32 = res32;
      end else check("hold32", res32, lastRes32);
      busyExp32 = 1'b0;
      if (q32.size() > 0) busyExp32 = (cyc >= q32[0].doneEdge - LAT32);
      check("busy32", busy32, busyExp32);
      prevDone32 = done32;
    end
  end

  always @(negedge clk) begin
    if (rst8) begin
      lastRes8  = '0;
      prevDone8 = 1'b0;
    end else begin
      if (done8) begin
        if (q8.size() == 0) check("unexpected_done8", 1, 0);
        else begin
          e8 = q8.pop_front();
          check("result8", res8, e8.res);
          check("dbz8", dbz8, e8.dbz);
          check("latency8", cyc, e8.doneEdge);
        end
        check("donePulse8", prevDone8, 0);
        lastRes8 = res8;
      end else check("hold8", res8, lastRes8);
      busyExp8 = 1'b0;
      if (q8.size() > 0) busyExp8 = (cyc >= q8[0].doneEdge - LAT8);
      check("busy8", busy8, busyExp8);
      prevDone8 = done8;
    end
  end

  task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    @(negedge clk);
    while (busy32 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("issue32_timeout", busy32, 0);
    start32 = 1'b1;
    op32 = op;
    a32 = a;
    b32 = b;
    q32.push_back(refModel(32, op, a, b, cyc + 1 + LAT32));
    @(posedge clk);
    #1;
    start32 = 1'b0;
    op32 = 3'($urandom);
    a32 = $urandom;
    b32 = $urandom;
  endtask

  task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int guard = 0;
    @(negedge clk);
    while (busy8 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("issue8_timeout", busy8, 0);
    start8 = 1'b1;
    op8 = op;
    a8 = a;
    b8 = b;
    q8.push_back(refModel(8, op, 32'(a), 32'(b), cyc + 1 + LAT8));
    @(posedge clk);
    #1;
    start8 = 1'b0;
    op8 = 3'($urandom);
    a8 = 8'($urandom);
    b8 = 8'($urandom);
  endtask

  task automatic drive32();
    int snap;
    logic [31:0] ra, rb;
    rst32 = 1'b1; start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy32", busy32, 0);
    check("reset_done32", done32, 0);
    check("reset_result32", res32, 0);
    check("reset_dbz32", dbz32, 0);
    @(negedge clk);
    rst32 = 1'b0;

    issue32(3'd1, 32'h0001_2345, 32'h0000_1000);
    issue32(3'd0, 32'hFFFF_FFF9, 32'd6);
    issue32(3'd2, 32'hFFFF_FFF9, 32'd2);
    issue32(3'd4, 32'hFFFF_FFF9, 32'd2);
    issue32(3'd3, 32'hFFFF_FFF9, 32'd2);
    issue32(3'd5, 32'hFFFF_FFF9, 32'd2);
    issue32(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue32(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    issue32(3'd3, 32'd5, 32'd0);
    issue32(3'd1, 32'd3, 32'd3);
    issue32(3'd6, 32'd11, 32'd0);

    // Start pulses while a multiply runs must be ignored.
    issue32(3'd1, 32'h0000_1234, 32'h0000_5678);
    repeat (4) @(negedge clk);
    start32 = 1'b1; op32 = 3'd3; a32 = 32'd999; b32 = 32'd0;
    @(posedge clk); #1 start32 = 1'b0;
    repeat (14) @(negedge clk);
    start32 = 1'b1; op32 = 3'd0; a32 = 32'hDEAD_BEEF; b32 = 32'd77;
    @(posedge clk); #1 start32 = 1'b0;

    // Abort a divide mid-run.
    issue32(3'd3, 32'hCAFE_0000, 32'd7);
    repeat (9) @(negedge clk);
    rst32 = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy32", busy32, 0);
    check("abort_done32", done32, 0);
    check("abort_result32", res32, 0);
    check("abort_dbz32", dbz32, 0);
    q32.delete();
    snap = doneCount32;
    @(negedge clk);
    rst32 = 1'b0;
    repeat (45) @(negedge clk);
    check("abort_no_done32", doneCount32, snap);
    issue32(3'd3, 32'd100, 32'd7);

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'hFFFF_FFFF;
      issue32(3'($urandom_range(0, 7)), ra, rb);
    end

    for (int g = 0; g < 200 && q32.size() > 0; g++) @(negedge clk);
    check("drain32", q32.size(), 0);
  endtask

  task automatic drive8();
    logic [7:0] ra, rb;
    rst8 = 1'b1; start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy8", busy8, 0);
    check("reset_result8", res8, 0);
    @(negedge clk);
    rst8 = 1'b0;

    issue8(3'd0, 8'hF9, 8'h06);
    issue8(3'd2, 8'h80, 8'hFF);
    issue8(3'd4, 8'h80, 8'hFF);
    issue8(3'd5, 8'h17, 8'h00);

    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom);
      issue8(3'($urandom_range(0, 7)), ra, rb);
    end

    for (int g = 0; g < 100 && q8.size() > 0; g++) @(negedge clk);
    check("drain8", q8.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      drive32();
      drive8();
    join
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
